// File: rtl/angle_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// angle_cmd_sequencer
//
// Purpose:
//   Decodes 2-byte angle commands arriving from uart_rx, validates module ID,
//   parity and angle range, and holds an accepted angle as "pending" until the
//   next rising edge of the (asynchronous) shoot line hands it to the
//   modulator. Every completed frame addressed to this board is answered with
//   an ACK or NAK byte through uart_tx. Runs on the clk24 domain.
//
//   Frame format: byte1 = {ID[3:0], A[11:8]}, byte2 = A[7:0].
//
// Ports:
//   i_clk             system clock (clk24)
//   i_reset           asynchronous reset, active-high
//   i_rx_done         1-cycle pulse, uart_rx byte ready
//   i_rx_data         received byte
//   i_rx_parity_error uart_rx parity flag, qualified by i_rx_done
//   i_tx_busy         uart_tx busy
//   o_tx_start        1-cycle start pulse to uart_tx
//   o_tx_data         reply byte (ACK_BYTE / NAK_BYTE)
//   i_shoot           asynchronous shoot line from the connector
//   o_angle           angle applied to the modulator
//   o_angle_update    1-cycle pulse when o_angle is loaded
//   o_pending         a valid angle is waiting for shoot
//   o_err_count       saturating count of rejected/dropped bytes and frames
// ---------------------------------------------------------------------------
module angle_cmd_sequencer #(
    parameter logic [3:0]  MODULE_ID      = 4'd0,
    parameter int          TIMEOUT_CYCLES = 24000,
    parameter logic [11:0] ANGLE_MAX      = 12'd3599,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5,
    parameter logic [7:0]  NAK_BYTE       = 8'h5A
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_rx_done,
    input  logic [7:0]  i_rx_data,
    input  logic        i_rx_parity_error,
    input  logic        i_tx_busy,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_data,
    input  logic        i_shoot,
    output logic [11:0] o_angle,
    output logic        o_angle_update,
    output logic        o_pending,
    output logic [7:0]  o_err_count
);

    // Wide enough to hold TIMEOUT_CYCLES-1 even for tiny timeouts.
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_LO,
        ST_CHECK,
        ST_TX_REQ,
        ST_TX_WAIT
    } state_t;

    state_t r_state;
    state_t w_next_state;

    logic [7:0]      r_byte1;
    logic [7:0]      r_byte2;
    logic            r_parity2;
    logic [TO_W-1:0] r_to_cnt;
    logic [1:0]      r_txw_cnt;
    logic            r_txw_busy_seen;
    logic [11:0]     r_pend_angle;
    logic            r_pending;
    logic [11:0]     r_angle;
    logic            r_angle_update;
    logic [7:0]      r_tx_data;
    logic [7:0]      r_err_count;
    logic [1:0]      r_shoot_sync;
    logic            r_shoot_prev;

    logic [11:0] w_frame_angle;
    logic        w_id_ok;
    logic        w_frame_ok;
    logic        w_shoot_edge;
    logic        w_load_b1;
    logic        w_load_b2;
    logic        w_byte1_perr;
    logic        w_timeout;
    logic        w_accept;
    logic        w_reject;
    logic        w_drop;
    logic        w_tx_start;
    logic [1:0]  w_err_add;
    logic [8:0]  w_err_sum;

    assign w_frame_angle = {r_byte1[3:0], r_byte2};
    assign w_id_ok       = (r_byte1[7:4] == MODULE_ID);
    assign w_frame_ok    = !r_parity2 && w_id_ok && (w_frame_angle <= ANGLE_MAX);
    assign w_shoot_edge  = r_shoot_sync[1] && !r_shoot_prev;

    // State register.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode plus the single-cycle strobes that steer the datapath.
    // tx_start is decoded here so it appears in the TX_REQ cycle itself, which
    // keeps the byte2-to-start latency at two cycles when the UART is idle.
    always_comb begin
        w_next_state = r_state;
        w_load_b1    = 1'b0;
        w_load_b2    = 1'b0;
        w_byte1_perr = 1'b0;
        w_timeout    = 1'b0;
        w_accept     = 1'b0;
        w_reject     = 1'b0;
        w_drop       = 1'b0;
        w_tx_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_rx_done) begin
                    if (i_rx_parity_error) begin
                        w_byte1_perr = 1'b1;
                    end else begin
                        w_load_b1    = 1'b1;
                        w_next_state = ST_WAIT_LO;
                    end
                end
            end
            ST_WAIT_LO: begin
                if (i_rx_done) begin
                    w_load_b2    = 1'b1;
                    w_next_state = ST_CHECK;
                end else if (r_to_cnt == TO_LAST) begin
                    w_timeout    = 1'b1;
                    w_next_state = ST_IDLE;
                end
            end
            ST_CHECK: begin
                w_drop = i_rx_done;
                if (w_frame_ok) begin
                    w_accept = 1'b1;
                end else begin
                    w_reject = 1'b1;
                end
                // Frames for other boards share the bus: stay silent.
                w_next_state = w_id_ok ? ST_TX_REQ : ST_IDLE;
            end
            ST_TX_REQ: begin
                w_drop = i_rx_done;
                if (!i_tx_busy) begin
                    w_tx_start   = 1'b1;
                    w_next_state = ST_TX_WAIT;
                end
            end
            ST_TX_WAIT: begin
                w_drop = i_rx_done;
                if (r_txw_busy_seen && !i_tx_busy) begin
                    w_next_state = ST_IDLE;
                end else if (!r_txw_busy_seen && !i_tx_busy && (r_txw_cnt == 2'd3)) begin
                    // UART never went busy: the start pulse was lost.
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // Frame capture, inter-byte timeout counter and TX_WAIT guard counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_byte1         <= 8'h00;
            r_byte2         <= 8'h00;
            r_parity2       <= 1'b0;
            r_to_cnt        <= '0;
            r_txw_cnt       <= 2'd0;
            r_txw_busy_seen <= 1'b0;
        end else begin
            if (w_load_b1) begin
                r_byte1 <= i_rx_data;
            end
            if (w_load_b2) begin
                r_byte2   <= i_rx_data;
                r_parity2 <= i_rx_parity_error;
            end
            if (w_load_b1) begin
                r_to_cnt <= '0;
            end else if (r_state == ST_WAIT_LO) begin
                r_to_cnt <= r_to_cnt + 1'b1;
            end
            if (w_tx_start) begin
                r_txw_cnt       <= 2'd0;
                r_txw_busy_seen <= 1'b0;
            end else if (r_state == ST_TX_WAIT) begin
                if (r_txw_cnt != 2'd3) begin
                    r_txw_cnt <= r_txw_cnt + 2'd1;
                end
                if (i_tx_busy) begin
                    r_txw_busy_seen <= 1'b1;
                end
            end
        end
    end

    // Reply byte. It is settled in CHECK, well before TX_REQ raises tx_start.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_tx_data <= NAK_BYTE;
        end else if (w_accept) begin
            r_tx_data <= ACK_BYTE;
        end else if (w_reject) begin
            r_tx_data <= NAK_BYTE;
        end
    end

    // A byte dropped while busy can coincide with a rejected frame in CHECK,
    // so up to two errors may be added in one cycle.
    assign w_err_add = {1'b0, (w_byte1_perr | w_timeout | w_reject)} + {1'b0, w_drop};
    assign w_err_sum = {1'b0, r_err_count} + {7'd0, w_err_add};

    // Saturating error counter.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_err_count <= 8'h00;
        end else if (w_err_sum[8]) begin
            r_err_count <= 8'hFF;
        end else begin
            r_err_count <= w_err_sum[7:0];
        end
    end

    // Shoot line: two-flop synchroniser followed by a rising-edge detector.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_shoot_sync <= 2'b00;
            r_shoot_prev <= 1'b0;
        end else begin
            r_shoot_sync <= {r_shoot_sync[0], i_shoot};
            r_shoot_prev <= r_shoot_sync[1];
        end
    end

    // Pending angle and its hand-off to the modulator. If an accept lands on
    // the same cycle as a shoot edge, the old pending value is applied and the
    // freshly accepted one stays pending.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_pend_angle   <= 12'd0;
            r_pending      <= 1'b0;
            r_angle        <= 12'd0;
            r_angle_update <= 1'b0;
        end else begin
            r_angle_update <= 1'b0;
            if (w_shoot_edge && r_pending) begin
                r_angle        <= r_pend_angle;
                r_angle_update <= 1'b1;
            end
            if (w_accept) begin
                r_pend_angle <= w_frame_angle;
                r_pending    <= 1'b1;
            end else if (w_shoot_edge && r_pending) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign o_tx_start     = w_tx_start;
    assign o_tx_data      = r_tx_data;
    assign o_angle        = r_angle;
    assign o_angle_update = r_angle_update;
    assign o_pending      = r_pending;
    assign o_err_count    = r_err_count;

endmodule

// File: tb/tb_angle_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_angle_cmd_sequencer
//
// Purpose:
//   Directed bench for angle_cmd_sequencer. Inputs change 1 time unit after a
//   rising clock edge; outputs are read away from the rising edge. A small
//   uart_tx stand-in raises busy for a few cycles after each tx_start, and a
//   monitor counts tx_start / angle_update pulses and remembers the last
//   byte sent.
// ---------------------------------------------------------------------------
module tb_angle_cmd_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        rxDone = 1'b0;
    logic [7:0]  rxData = 8'h00;
    logic        rxParityError = 1'b0;
    logic        busyManual = 1'b0;
    logic        busyAuto = 1'b0;
    logic        txBusy;
    logic        txStart;
    logic [7:0]  txData;
    logic        shoot = 1'b0;
    logic [11:0] angle;
    logic        angleUpdate;
    logic        pending;
    logic [7:0]  errCount;

    int          checks = 0;
    int          failures = 0;
    int          txCount = 0;
    int          updCount = 0;
    logic [7:0]  lastTx = 8'h00;

    assign txBusy = busyManual | busyAuto;

    angle_cmd_sequencer dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_rx_done         (rxDone),
        .i_rx_data         (rxData),
        .i_rx_parity_error (rxParityError),
        .i_tx_busy         (txBusy),
        .o_tx_start        (txStart),
        .o_tx_data         (txData),
        .i_shoot           (shoot),
        .o_angle           (angle),
        .o_angle_update    (angleUpdate),
        .o_pending         (pending),
        .o_err_count       (errCount)
    );

    always #5 clk = ~clk;

    // Pulse monitor, sampled on the falling edge.
    always @(negedge clk) begin
        if (txStart === 1'b1) begin
            txCount = txCount + 1;
            lastTx  = txData;
        end
        if (angleUpdate === 1'b1) begin
            updCount = updCount + 1;
        end
    end

    // uart_tx stand-in: busy for four cycles starting just after a start pulse.
    initial begin : uartModel
        int   busyLeft;
        logic sawStart;
        busyLeft = 0;
        forever begin
            @(negedge clk);
            sawStart = (txStart === 1'b1);
            @(posedge clk);
            #1;
            if (sawStart) busyLeft = 4;
            if (busyLeft > 0) begin
                busyAuto = 1'b1;
                busyLeft = busyLeft - 1;
            end else begin
                busyAuto = 1'b0;
            end
        end
    end

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents one byte from uart_rx as a single-cycle rx_done pulse.
    task automatic applyByte(input logic [7:0] data, input logic perr);
        @(posedge clk);
        #1;
        rxDone        = 1'b1;
        rxData        = data;
        rxParityError = perr;
        @(posedge clk);
        #1;
        rxDone        = 1'b0;
        rxParityError = 1'b0;
    endtask

    task automatic applyFrame(input logic [7:0] b1, input logic [7:0] b2, input logic perr2);
        applyByte(b1, 1'b0);
        applyByte(b2, perr2);
        waitCycles(15);
    endtask

    task automatic pulseShoot();
        @(posedge clk);
        #1;
        shoot = 1'b1;
        waitCycles(4);
        shoot = 1'b0;
        waitCycles(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        waitCycles(3);
        checks++; if (angle !== 12'd0) begin failures++; $display("[TB] FAIL reset_angle actual=%0d expected=0", angle); end
        checks++; if (pending !== 1'b0) begin failures++; $display("[TB] FAIL reset_pending actual=%0b expected=0", pending); end
        checks++; if (angleUpdate !== 1'b0) begin failures++; $display("[TB] FAIL reset_update actual=%0b expected=0", angleUpdate); end
        checks++; if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL reset_tx_start actual=%0b expected=0", txStart); end
        checks++; if (txData !== 8'h5A) begin failures++; $display("[TB] FAIL reset_tx_data actual=%0h expected=5a", txData); end
        checks++; if (errCount !== 8'h00) begin failures++; $display("[TB] FAIL reset_err actual=%0d expected=0", errCount); end
        reset = 1'b0;
        waitCycles(2);
    endtask

    task automatic test_accept_shoot();
        int t0;
        int u0;
        t0 = txCount;
        applyByte(8'h0E, 1'b0);
        applyByte(8'h0F, 1'b0);
        @(negedge clk);
        checks++; if (txStart !== 1'b0) begin failures++; $display("[TB] FAIL latency_early actual=%0b expected=0", txStart); end
        @(negedge clk);
        checks++; if (txStart !== 1'b1) begin failures++; $display("[TB] FAIL latency_2cyc actual=%0b expected=1", txStart); end
        waitCycles(15);
        checks++; if (txCount !== t0 + 1) begin failures++; $display("[TB] FAIL accept_tx_count actual=%0d expected=%0d", txCount, t0 + 1); end
        checks++; if (lastTx !== 8'hA5) begin failures++; $display("[TB] FAIL accept_ack actual=%0h expected=a5", lastTx); end
        checks++; if (pending !== 1'b1) begin failures++; $display("[TB] FAIL accept_pending actual=%0b expected=1", pending); end
        checks++; if (angle !== 12'd0) begin failures++; $display("[TB] FAIL accept_angle_held actual=%0d expected=0", angle); end
        checks++; if (errCount !== 8'd0) begin failures++; $display("[TB] FAIL accept_err actual=%0d expected=0", errCount); end
        u0 = updCount;
        pulseShoot();
        checks++; if (angle !== 12'd3599) begin failures++; $display("[TB] FAIL shoot_angle actual=%0d expected=3599", angle); end
        checks++; if (updCount !== u0 + 1) begin failures++; $display("[TB] FAIL shoot_update_pulses actual=%0d expected=%0d", updCount, u0 + 1); end
        checks++; if (pending !== 1'b0) begin failures++; $display("[TB] FAIL shoot_pending_clear actual=%0b expected=0", pending); end
    endtask

    task automatic test_range_nak();
        int t0;
        int u0;
        t0 = txCount;
        applyFrame(8'h0E, 8'h10, 1'b0);
        checks++; if (txCount !== t0 + 1) begin failures++; $display("[TB] FAIL nak_tx_count actual=%0d expected=%0d", txCount, t0 + 1); end
        checks++; if (lastTx !== 8'h5A) begin failures++; $display("[TB] FAIL nak_byte actual=%0h expected=5a", lastTx); end
        checks++; if (errCount !== 8'd1) begin failures++; $display("[TB] FAIL nak_err actual=%0d expected=1", errCount); end
        checks++; if (pending !== 1'b0) begin failures++; $display("[TB] FAIL nak_pending actual=%0b expected=0", pending); end
        u0 = updCount;
        pulseShoot();
        checks++; if (angle !== 12'd3599) begin failures++; $display("[TB] FAIL nak_angle_kept actual=%0d expected=3599", angle); end
        checks++; if (updCount !== u0) begin failures++; $display("[TB] FAIL nak_no_update actual=%0d expected=%0d", updCount, u0); end
    endtask

    task automatic test_timeout();
        int t0;
        t0 = txCount;
        applyByte(8'h01, 1'b0);
        waitCycles(23999);
        checks++; if (errCount !== 8'd1) begin failures++; $display("[TB] FAIL timeout_not_early actual=%0d expected=1", errCount); end
        waitCycles(1);
        checks++; if (errCount !== 8'd2) begin failures++; $display("[TB] FAIL timeout_err actual=%0d expected=2", errCount); end
        waitCycles(10);
        checks++; if (txCount !== t0) begin failures++; $display("[TB] FAIL timeout_no_reply actual=%0d expected=%0d", txCount, t0); end
        applyFrame(8'h01, 8'h2C, 1'b0);
        checks++; if (txCount !== t0 + 1) begin failures++; $display("[TB] FAIL after_timeout_tx actual=%0d expected=%0d", txCount, t0 + 1); end
        checks++; if (lastTx !== 8'hA5) begin failures++; $display("[TB] FAIL after_timeout_ack actual=%0h expected=a5", lastTx); end
        pulseShoot();
        checks++; if (angle !== 12'd300) begin failures++; $display("[TB] FAIL after_timeout_angle actual=%0d expected=300", angle); end
    endtask

    task automatic test_latest_wins();
        int t0;
        int u0;
        t0 = txCount;
        applyFrame(8'h00, 8'h64, 1'b0);
        checks++; if (lastTx !== 8'hA5) begin failures++; $display("[TB] FAIL first_ack actual=%0h expected=a5", lastTx); end
        applyFrame(8'h00, 8'hC8, 1'b0);
        checks++; if (txCount !== t0 + 2) begin failures++; $display("[TB] FAIL two_acks_count actual=%0d expected=%0d", txCount, t0 + 2); end
        checks++; if (lastTx !== 8'hA5) begin failures++; $display("[TB] FAIL second_ack actual=%0h expected=a5", lastTx); end
        u0 = updCount;
        pulseShoot();
        checks++; if (angle !== 12'd200) begin failures++; $display("[TB] FAIL latest_angle actual=%0d expected=200", angle); end
        checks++; if (updCount !== u0 + 1) begin failures++; $display("[TB] FAIL latest_update actual=%0d expected=%0d", updCount, u0 + 1); end
        pulseShoot();
        checks++; if (updCount !== u0 + 1) begin failures++; $display("[TB] FAIL second_shoot_no_update actual=%0d expected=%0d", updCount, u0 + 1); end
        checks++; if (angle !== 12'd200) begin failures++; $display("[TB] FAIL second_shoot_angle actual=%0d expected=200", angle); end
    endtask

    task automatic test_busy_hold();
        int t0;
        t0 = txCount;
        busyManual = 1'b1;
        applyByte(8'h00, 1'b0);
        applyByte(8'h32, 1'b0);
        waitCycles(5);
        checks++; if (txCount !== t0) begin failures++; $display("[TB] FAIL busy_hold_no_start actual=%0d expected=%0d", txCount, t0); end
        applyByte(8'h77, 1'b0);
        waitCycles(1);
        checks++; if (errCount !== 8'd3) begin failures++; $display("[TB] FAIL busy_drop_err actual=%0d expected=3", errCount); end
        busyManual = 1'b0;
        waitCycles(15);
        checks++; if (txCount !== t0 + 1) begin failures++; $display("[TB] FAIL busy_release_start actual=%0d expected=%0d", txCount, t0 + 1); end
        checks++; if (lastTx !== 8'hA5) begin failures++; $display("[TB] FAIL busy_ack actual=%0h expected=a5", lastTx); end
        checks++; if (pending !== 1'b1) begin failures++; $display("[TB] FAIL busy_pending actual=%0b expected=1", pending); end
    endtask

    task automatic test_reset_mid();
        int t0;
        applyByte(8'h00, 1'b0);
        waitCycles(3);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (pending !== 1'b0) begin failures++; $display("[TB] FAIL async_reset_pending actual=%0b expected=0", pending); end
        checks++; if (angle !== 12'd0) begin failures++; $display("[TB] FAIL async_reset_angle actual=%0d expected=0", angle); end
        checks++; if (errCount !== 8'd0) begin failures++; $display("[TB] FAIL async_reset_err actual=%0d expected=0", errCount); end
        checks++; if (txData !== 8'h5A) begin failures++; $display("[TB] FAIL async_reset_tx_data actual=%0h expected=5a", txData); end
        waitCycles(2);
        reset = 1'b0;
        waitCycles(2);
        t0 = txCount;
        applyFrame(8'h00, 8'h0B, 1'b0);
        checks++; if (txCount !== t0 + 1) begin failures++; $display("[TB] FAIL post_reset_tx actual=%0d expected=%0d", txCount, t0 + 1); end
        checks++; if (lastTx !== 8'hA5) begin failures++; $display("[TB] FAIL post_reset_ack actual=%0h expected=a5", lastTx); end
        pulseShoot();
        checks++; if (angle !== 12'd11) begin failures++; $display("[TB] FAIL post_reset_angle actual=%0d expected=11", angle); end
        checks++; if (errCount !== 8'd0) begin failures++; $display("[TB] FAIL post_reset_err actual=%0d expected=0", errCount); end
    endtask

    task automatic test_reject();
        int t0;
        t0 = txCount;
        applyFrame(8'h10, 8'h05, 1'b0);
        checks++; if (txCount !== t0) begin failures++; $display("[TB] FAIL id_mismatch_silent actual=%0d expected=%0d", txCount, t0); end
        checks++; if (errCount !== 8'd1) begin failures++; $display("[TB] FAIL id_mismatch_err actual=%0d expected=1", errCount); end
        applyByte(8'h00, 1'b1);
        waitCycles(2);
        checks++; if (errCount !== 8'd2) begin failures++; $display("[TB] FAIL byte1_parity_err actual=%0d expected=2", errCount); end
        applyFrame(8'h00, 8'h14, 1'b0);
        checks++; if (lastTx !== 8'hA5 || txCount !== t0 + 1) begin failures++; $display("[TB] FAIL after_parity_ack actual=%0h/%0d expected=a5/%0d", lastTx, txCount, t0 + 1); end
        applyFrame(8'h00, 8'h15, 1'b1);
        checks++; if (lastTx !== 8'h5A) begin failures++; $display("[TB] FAIL byte2_parity_nak actual=%0h expected=5a", lastTx); end
        checks++; if (errCount !== 8'd3) begin failures++; $display("[TB] FAIL byte2_parity_err actual=%0d expected=3", errCount); end
        pulseShoot();
        checks++; if (angle !== 12'd20) begin failures++; $display("[TB] FAIL nak_keeps_pending actual=%0d expected=20", angle); end
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 300; i++) begin
            applyByte(8'h00, 1'b1);
        end
        waitCycles(2);
        checks++; if (errCount !== 8'hFF) begin failures++; $display("[TB] FAIL err_saturate actual=%0h expected=ff", errCount); end
    endtask

    initial begin
        test_reset();
        test_accept_shoot();
        test_range_nak();
        test_timeout();
        test_latest_wins();
        test_busy_hold();
        test_reset_mid();
        test_reject();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
